// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX byte port among NUM_REQ sources.
// Optional requester-stall timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 32,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 start_uart_tx,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_fifo_ready,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP1 = 2'd2,
    S_GAP2 = 2'd3
  } state_t;

  state_t           state_p0;
  state_t           state_nx;
  logic [GID_W-1:0] rr_ptr_p0;
  logic [7:0]       burst_cnt_p0;
  logic             last_p0;

  logic             scan_found;
  logic [GID_W-1:0] scan_idx;
  logic [GID_W-1:0] scan_pos;
  logic             gnt_valid;
  logic             gnt_last;
  logic [7:0]       gnt_byte;
  logic             xfer;
  logic             release_c;
  logic             tmo;

  // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
  function automatic logic [GID_W-1:0] ptr_inc(input logic [GID_W-1:0] p);
    if (p == GID_W'(NUM_REQ - 1)) return '0;
    return p + GID_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_byte  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_byte  = req_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_p0;
    scan_pos   = rr_ptr_p0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!scan_found && req_valid[scan_pos]) begin
        scan_found = 1'b1;
        scan_idx   = scan_pos;
      end
      scan_pos = ptr_inc(scan_pos);
    end
  end

  assign xfer      = (state_p0 == S_SEND) && gnt_valid && uart_tx_fifo_ready;
  assign release_c = last_p0 || (burst_cnt_p0 >= 8'(MAX_BURST));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);
  logic [TMO_W-1:0] idle_cnt_p0;

  // Only requester stalls count; UART back-pressure never advances the counter.
  assign tmo = (state_p0 == S_SEND) && !gnt_valid &&
               (idle_cnt_p0 == TMO_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_p0   <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tmo;
      if ((state_p0 == S_IDLE) || xfer || tmo)
        idle_cnt_p0 <= '0;
      else if ((state_p0 == S_SEND) && !gnt_valid)
        idle_cnt_p0 <= idle_cnt_p0 + TMO_W'(1);
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (IDLE_TIMEOUT > 0);
  assign tmo            = 1'b0;
  assign timeout_pulse  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_p0 <= S_IDLE;
    else          state_p0 <= state_nx;
  end

  // Next state: two gap cycles let the UART refresh its one-cycle-late ready flag.
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      S_IDLE:  if (scan_found) state_nx = S_SEND;
      S_SEND: begin
        if (xfer)     state_nx = S_GAP1;
        else if (tmo) state_nx = S_IDLE;
      end
      S_GAP1:  state_nx = S_GAP2;
      S_GAP2:  state_nx = release_c ? S_IDLE : S_SEND;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs: only the granted requester sees the UART ready flag, and only in SEND.
  always_comb begin
    req_ready = '0;
    if (state_p0 == S_SEND) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == GID_W'(i)) req_ready[i] = uart_tx_fifo_ready;
      end
    end
  end

  // Transfer stage: write pulse, byte, grant bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_uart_tx <= 1'b0;
      uart_tx_data  <= 8'h00;
      grant_id      <= '0;
      rr_ptr_p0     <= '0;
      burst_cnt_p0  <= 8'h00;
      last_p0       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      start_uart_tx <= xfer;
      busy          <= (state_nx != S_IDLE);
      if (xfer) begin
        uart_tx_data <= gnt_byte;
        burst_cnt_p0 <= sat_inc8(burst_cnt_p0);
        last_p0      <= gnt_last;
      end
      if ((state_p0 == S_IDLE) && scan_found) begin
        grant_id     <= scan_idx;
        burst_cnt_p0 <= 8'h00;
      end
      if (((state_p0 == S_GAP2) && release_c) || tmo)
        rr_ptr_p0 <= ptr_inc(grant_id);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter; expected byte order comes from a
// message-level round-robin model over per-requester byte queues.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IT = 16;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            start_uart_tx;
  logic [7:0]      uart_tx_data;
  logic            uart_tx_fifo_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .start_uart_tx(start_uart_tx),
    .uart_tx_data(uart_tx_data), .uart_tx_fifo_ready(uart_tx_fifo_ready),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mptr     = 0;
  logic [8:0]  src_q [NR][$];
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input bit last);
    src_q[id].push_back({last, d});
  endtask

  task automatic drive_sources();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Called just after a negedge: apply inputs, then retire bytes accepted at the posedge.
  task automatic drive_cycle(input bit rdy);
    logic [NR-1:0] acc;
    uart_tx_fifo_ready = rdy;
    drive_sources();
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive_sources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mptr    = 0;
  endtask

  // Message-level model: each entry is {first_of_grant, id[2:0], byte}.
  task automatic build_expected();
    logic [8:0] cp [NR][$];
    logic [8:0] e;
    int         sel, cnt, idx;
    bit         found, stop;
    for (int i = 0; i < NR; i++) cp[i] = src_q[i];
    exp_q.delete();
    stop = 1'b0;
    while (!stop) begin
      found = 1'b0;
      sel   = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (mptr + k) % NR;
        if (!found && cp[idx].size() > 0) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      if (!found) break;
      cnt = 0;
      do begin
        e = cp[sel].pop_front();
        cnt++;
        exp_q.push_back({(cnt == 1), 3'(sel), e[7:0]});
      end while (!e[8] && cnt < MB && cp[sel].size() > 0);
      if (e[8] || cnt >= MB) mptr = (sel + 1) % NR;
      else stop = 1'b1;
    end
  endtask

  // mode 0: ready held high; 1: random stalls; 2: one 50-cycle stall after the third byte.
  task automatic run_traffic(input int budget, input int mode, input bit expect_idle);
    int          last_cyc, rise_cyc, low_run, stall_left, pulses, quiet, total;
    bit          stalled_since, rdy, rdy_prev, did;
    logic [11:0] e;
    logic [NR-1:0] allowed;
    build_expected();
    total = exp_q.size();
    last_cyc = -1; rise_cyc = -1; low_run = 0; stall_left = 0;
    pulses = 0; quiet = 0; stalled_since = 1'b0; did = 1'b0;
    rdy_prev = uart_tx_fifo_ready;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (start_uart_tx) begin
        check("pulse_needs_ready", rdy_prev, 1);
        if (exp_q.size() == 0) check("unexpected_pulse", start_uart_tx, 0);
        else begin
          e = exp_q.pop_front();
          check("tx_data", uart_tx_data, e[7:0]);
          check("tx_grant", grant_id, e[10:8]);
          if (last_cyc >= 0) begin
            if (!stalled_since) check("pulse_gap", cyc - last_cyc, e[11] ? 4 : 3);
            else check("pulse_gap_min", (cyc - last_cyc) >= 3, 1);
          end
          if (rise_cyc >= 0) check("pulse_after_ready", cyc, rise_cyc + 1);
        end
        pulses++;
        last_cyc = cyc; stalled_since = 1'b0; rise_cyc = -1; quiet = 0;
      end else quiet++;
      if (exp_q.size() > 0) begin
        allowed = rdy_prev ? (NR'(1) << exp_q[0][10:8]) : '0;
        check("req_ready_legal", req_ready & ~allowed, 0);
      end
      if (exp_q.size() == 0 && quiet >= 8) break;
      if (stall_left > 0) begin
        stall_left--;
        rdy = 1'b0;
      end else if (mode == 2 && pulses == 3 && !did) begin
        did = 1'b1; stall_left = 49; rdy = 1'b0;
      end else if (mode == 1 && $urandom_range(0, 30) == 0) begin
        stall_left = $urandom_range(4, 11); rdy = 1'b0;
      end else if (mode == 1) begin
        rdy = ($urandom_range(0, 7) != 0);
      end else begin
        rdy = 1'b1;
      end
      if (!rdy) begin
        low_run++;
        stalled_since = 1'b1;
      end else begin
        if (low_run >= 5 && exp_q.size() > 0) rise_cyc = cyc;
        low_run = 0;
      end
      rdy_prev = rdy;
      drive_cycle(rdy);
    end
    check("traffic_drained", exp_q.size(), 0);
    check("pulse_count", pulses, total);
    if (expect_idle) check("idle_after", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset_n = 1'b0;
    uart_tx_fifo_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_start", start_uart_tx, 0);
    check("rst_data", uart_tx_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_pulse, 0);
    reset_n = 1'b1;

    // "OK\n" from requester 1
    push_byte(1, 8'h4F, 0); push_byte(1, 8'h4B, 0); push_byte(1, 8'h0A, 1);
    run_traffic(200, 0, 1);

    // Requesters 0 and 2 from pointer 0, then pointer 3 shown by 3 winning over 0
    do_reset();
    push_byte(0, 8'h10, 0); push_byte(0, 8'h11, 1);
    push_byte(2, 8'h20, 0); push_byte(2, 8'h21, 1);
    run_traffic(200, 0, 1);
    push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 0); push_byte(0, 8'hA3, 1);
    push_byte(3, 8'h30, 0); push_byte(3, 8'h31, 1);
    run_traffic(400, 2, 1);

    // Burst rotation: requester 1 streams 10 bytes with no end marker
    for (int b = 0; b < 10; b++) push_byte(1, 8'(8'h50 + b), 0);
    push_byte(3, 8'h3A, 0); push_byte(3, 8'h3B, 1);
    run_traffic(400, 0, 0);

    // Requester 1 now starved while holding the grant; requester 2 waits
    push_byte(2, 8'h77, 1);
`ifdef UART_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (timeout_pulse) seen = 1'b1;
      else drive_cycle(1);
    end
    check("timeout_seen", seen, 1);
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("hold_no_pulse", start_uart_tx, 0);
      drive_cycle(1);
    end
    @(negedge clk);
    check("hold_grant", grant_id, 1);
    check("hold_busy", busy, 1);
    check("hold_req_ready", req_ready, 4'b0010);
`endif

    // Asynchronous reset while in GAP1
    do_reset();
    push_byte(2, 8'hC0, 0); push_byte(2, 8'hC1, 0); push_byte(2, 8'hC2, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (start_uart_tx) seen = 1'b1;
      else drive_cycle(1);
    end
    check("gap1_reached", seen, 1);
    reset_n = 1'b0;
    #1;
    check("gap1rst_start", start_uart_tx, 0);
    check("gap1rst_data", uart_tx_data, 0);
    check("gap1rst_grant", grant_id, 0);
    check("gap1rst_busy", busy, 0);
    check("gap1rst_req_ready", req_ready, 0);
    check("gap1rst_timeout", timeout_pulse, 0);
    do_reset();
    push_byte(3, 8'hD3, 1); push_byte(1, 8'hD1, 1);
    run_traffic(200, 0, 1);

    // Randomized message mix with random UART back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) begin
        int nmsg, len;
        nmsg = $urandom_range(0, 2);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
        end
      end
      run_traffic(3000, 1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
